// File: rtl/aes_kexp_iter_pkg.sv
// Shared constants, types and helpers for the iterative AES key expander.
package aes_kexp_iter_pkg;

  localparam int NB         = 4;
  localparam int NK_MAX     = 8;
  localparam int NR_MAX     = 14;
  localparam int KEXP_WORDS = NB * (NR_MAX + 1);

  typedef enum logic [1:0] {KLEN128, KLEN192, KLEN256, KLEN_BAD} aes_klen_t;
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_EXPAND, ST_DONE} kexp_state_t;

  typedef logic [31:0]  aes_word_t;
  typedef logic [127:0] aes_rkey_t;

  // Forward AES S-box, element 0 first.
  localparam logic [0:255][7:0] SBOX = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_kexp_iter_subword.sv
// SubWord: four parallel S-box lookups, shared by both SubWord cases of the schedule.
module aes_kexp_iter_subword
  import aes_kexp_iter_pkg::*;
(
  input  aes_word_t word_in,
  output aes_word_t word_out
);

  assign word_out = {SBOX[word_in[31:24]], SBOX[word_in[23:16]],
                     SBOX[word_in[15:8]],  SBOX[word_in[7:0]]};

endmodule

// File: rtl/aes_kexp_iter.sv
// Iterative AES-128/192/256 key expander: one schedule word per clock into a
// flop-based schedule RAM, with a registered 128-bit round-key read port.
module aes_kexp_iter
  import aes_kexp_iter_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [255:0] key_in,
  input  logic [1:0]   key_len,
  input  logic         start,
  output logic         busy,
  output logic         ready,
  output logic         err,
  input  logic         rk_rd,
  input  logic [3:0]   rk_addr,
  output logic [127:0] rk_data,
  output logic         rk_valid,
  output logic [3:0]   nr_out
);

  kexp_state_t state_q, state_d;
  logic [3:0]  nk_q, nk_d, nr_q, nr_d;
  logic [5:0]  i_q, i_d;
  logic [2:0]  j_q, j_d;
  logic [7:0]  rcon_q, rcon_d;
  logic        busy_q, busy_d, ready_q, ready_d, err_q, err_d;
  logic        rk_valid_q, rk_valid_d;
  aes_rkey_t   rk_data_q, rk_data_d;
  aes_word_t   win_q [NK_MAX];
  aes_word_t   win_d [NK_MAX];
  aes_word_t   ram_q [KEXP_WORDS];
  aes_word_t   ram_d [KEXP_WORDS];

  aes_klen_t    klen;
  logic [3:0]   new_nk, new_nr;
  logic [255:0] key_shift;
  logic [2:0]   oldest_idx;
  logic [5:0]   last_idx, rd_base;
  aes_word_t    temp, sub_in, sub_out, temp_mix, w_new;

  assign klen       = aes_klen_t'(key_len);
  assign new_nk     = 4'd4 + {1'b0, key_len, 1'b0};
  assign new_nr     = 4'd10 + {1'b0, key_len, 1'b0};
  // Right-align the Nk key words so w[Nk-1] lands in the newest window slot.
  assign key_shift  = key_in >> {4'd8 - new_nk, 5'd0};
  assign oldest_idx = 3'(4'd8 - nk_q);
  assign last_idx   = {nr_q, 2'b00} + 6'd3;
  assign rd_base    = {rk_addr, 2'b00};
  assign temp       = win_q[NK_MAX-1];
  assign sub_in     = (j_q == 3'd0) ? {temp[23:0], temp[31:24]} : temp;

  aes_kexp_iter_subword u_subword (
    .word_in  (sub_in),
    .word_out (sub_out)
  );

  // Next schedule word from the window: w[i] = w[i-Nk] ^ f(w[i-1]).
  always_comb begin
    temp_mix = temp;
    if (j_q == 3'd0)
      temp_mix = sub_out ^ {rcon_q, 24'h0};
    else if (nk_q == 4'd8 && j_q == 3'd4)
      temp_mix = sub_out;
    w_new = win_q[oldest_idx] ^ temp_mix;
  end

  // Control FSM, window shifting and schedule RAM writes.
  always_comb begin
    state_d = state_q;
    nk_d    = nk_q;
    nr_d    = nr_q;
    i_d     = i_q;
    j_d     = j_q;
    rcon_d  = rcon_q;
    busy_d  = busy_q;
    ready_d = ready_q;
    err_d   = 1'b0;
    win_d   = win_q;
    ram_d   = ram_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          if (klen == KLEN_BAD) begin
            err_d = 1'b1;
          end else begin
            state_d = ST_LOAD;
            nk_d    = new_nk;
            nr_d    = new_nr;
            busy_d  = 1'b1;
            ready_d = 1'b0;
            for (int m = 0; m < NK_MAX; m++)
              win_d[m] = key_shift[32*(NK_MAX-1-m) +: 32];
          end
        end
      end
      ST_LOAD: begin
        for (int k = 0; k < NK_MAX; k++)
          if (k < int'(nk_q))
            ram_d[k] = win_q[3'(int'(oldest_idx) + k)];
        i_d     = {2'b00, nk_q};
        j_d     = 3'd0;
        rcon_d  = 8'h01;
        state_d = ST_EXPAND;
      end
      ST_EXPAND: begin
        ram_d[i_q] = w_new;
        for (int m = 0; m < NK_MAX-1; m++)
          win_d[m] = win_q[m+1];
        win_d[NK_MAX-1] = w_new;
        i_d = i_q + 6'd1;
        j_d = (j_q == 3'(nk_q - 4'd1)) ? 3'd0 : j_q + 3'd1;
        if (j_q == 3'd0)
          rcon_d = xtime(rcon_q);
        if (i_q == last_idx) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          ready_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Round-key read port: only a complete schedule is ever served.
  always_comb begin
    rk_valid_d = 1'b0;
    rk_data_d  = '0;
    if (rk_rd && ready_q && rk_addr <= nr_q) begin
      rk_valid_d = 1'b1;
      rk_data_d  = {ram_q[rd_base], ram_q[rd_base + 6'd1],
                    ram_q[rd_base + 6'd2], ram_q[rd_base + 6'd3]};
    end
  end

  // Control and output registers; reset abandons any expansion in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      nk_q       <= '0;
      nr_q       <= '0;
      i_q        <= '0;
      j_q        <= '0;
      rcon_q     <= 8'h01;
      busy_q     <= 1'b0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
      rk_valid_q <= 1'b0;
      rk_data_q  <= '0;
      for (int m = 0; m < NK_MAX; m++)
        win_q[m] <= '0;
    end else begin
      state_q    <= state_d;
      nk_q       <= nk_d;
      nr_q       <= nr_d;
      i_q        <= i_d;
      j_q        <= j_d;
      rcon_q     <= rcon_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
      err_q      <= err_d;
      rk_valid_q <= rk_valid_d;
      rk_data_q  <= rk_data_d;
      win_q      <= win_d;
    end
  end

  // Schedule storage needs no reset: it is only readable once ready is set.
  always_ff @(posedge clk) begin
    ram_q <= ram_d;
  end

  assign busy     = busy_q;
  assign ready    = ready_q;
  assign err      = err_q;
  assign rk_valid = rk_valid_q;
  assign rk_data  = rk_data_q;
  assign nr_out   = nr_q;

endmodule

// File: tb/tb_aes_kexp_iter.sv
// Self-checking bench for aes_kexp_iter: independent key-schedule model with
// a read scoreboard, plus known-answer checks from FIPS-197.
module tb_aes_kexp_iter;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] key_in;
  logic [1:0]   key_len;
  logic         start;
  logic         busy, ready, err;
  logic         rk_rd;
  logic [3:0]   rk_addr;
  logic [127:0] rk_data;
  logic         rk_valid;
  logic [3:0]   nr_out;

  always #5 clk = ~clk;

  aes_kexp_iter dut (
    .clk      (clk),
    .rst      (rst),
    .key_in   (key_in),
    .key_len  (key_len),
    .start    (start),
    .busy     (busy),
    .ready    (ready),
    .err      (err),
    .rk_rd    (rk_rd),
    .rk_addr  (rk_addr),
    .rk_data  (rk_data),
    .rk_valid (rk_valid),
    .nr_out   (nr_out)
  );

  localparam logic [255:0] KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] KEY192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] KEY256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  typedef struct packed {
    logic         valid;
    logic [127:0] data;
  } rd_exp_t;

  int        assert_cnt = 0;
  int        fail_cnt   = 0;
  logic [7:0]  sbox_ref [256];
  logic [31:0] cur_w [60];
  int        cur_nr    = 0;
  bit        cur_ready = 1'b0;
  rd_exp_t   sb [$];

  task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    assert_cnt++;
    if (obs !== exp) begin
      fail_cnt++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p  = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int n = 0; n < 8; n++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  // S-box from first principles: GF(2^8) inverse followed by the affine map.
  task automatic build_sbox();
    logic [7:0] inv, s;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      if (a != 0)
        for (int b = 1; b < 256; b++)
          if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sbox_ref[a] = s;
    end
  endtask

  function automatic logic [31:0] sub_word_ref(input logic [31:0] w);
    return {sbox_ref[w[31:24]], sbox_ref[w[23:16]], sbox_ref[w[15:8]], sbox_ref[w[7:0]]};
  endfunction

  task automatic expand_model(input logic [255:0] key, input int klen);
    int nk = 4 + 2*klen;
    int nr = 10 + 2*klen;
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 60; i++) cur_w[i] = 32'h0;
    for (int i = 0; i < nk; i++) cur_w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = cur_w[i-1];
      if (i % nk == 0) begin
        rc = 8'h01;
        for (int r = 1; r < i/nk; r++) rc = gmul(rc, 8'h02);
        t = sub_word_ref({t[23:0], t[31:24]}) ^ {rc, 24'h0};
      end else if (nk > 6 && i % nk == 4) begin
        t = sub_word_ref(t);
      end
      cur_w[i] = cur_w[i-nk] ^ t;
    end
    cur_nr = nr;
  endtask

  function automatic rd_exp_t exp_read(input int a);
    rd_exp_t e;
    e.valid = 1'b0;
    e.data  = '0;
    if (cur_ready && a <= cur_nr) begin
      e.valid = 1'b1;
      e.data  = {cur_w[4*a], cur_w[4*a+1], cur_w[4*a+2], cur_w[4*a+3]};
    end
    return e;
  endfunction

  task automatic do_read(input int a, input string tag);
    rd_exp_t e;
    rk_rd   = 1'b1;
    rk_addr = 4'(a);
    sb.push_back(exp_read(a));
    tick();
    rk_rd = 1'b0;
    e = sb.pop_front();
    check_output($sformatf("%s_rd%0d_valid", tag, a), 128'(rk_valid), 128'(e.valid));
    check_output($sformatf("%s_rd%0d_data", tag, a), rk_data, e.data);
  endtask

  task automatic sweep_reads(input string tag);
    for (int a = 0; a < 16; a++) do_read(a, tag);
  endtask

  // Start an expansion and count edges until ready; optional disturbances.
  task automatic apply_stimulus(input logic [255:0] key, input int klen, input int exp_lat,
                                input bit disturb, input bit rd_at_start, input string tag);
    int cnt = 0;
    rd_exp_t e;
    key_in  = key;
    key_len = 2'(klen);
    start   = 1'b1;
    if (rd_at_start) begin
      rk_rd   = 1'b1;
      rk_addr = 4'(cur_nr);
      sb.push_back(exp_read(cur_nr));
    end
    expand_model(key, klen);
    cur_ready = 1'b0;
    while (cnt < 300) begin
      tick();
      cnt++;
      if (cnt == 1) begin
        start = 1'b0;
        check_output({tag, "_busy_load"}, 128'(busy), 128'(1'b1));
        check_output({tag, "_ready_drop"}, 128'(ready), 128'(1'b0));
        if (rd_at_start) begin
          rk_rd = 1'b0;
          e = sb.pop_front();
          check_output({tag, "_oldrd_valid"}, 128'(rk_valid), 128'(e.valid));
          check_output({tag, "_oldrd_data"}, rk_data, e.data);
        end
      end
      if (disturb && cnt == 10) begin
        start   = 1'b1;
        key_in  = ~key;
        key_len = 2'd2;
        rk_rd   = 1'b1;
        rk_addr = 4'd0;
        sb.push_back(exp_read(0));
      end
      if (disturb && cnt == 11) begin
        start   = 1'b0;
        key_in  = key;
        key_len = 2'(klen);
        rk_rd   = 1'b0;
        e = sb.pop_front();
        check_output({tag, "_exprd_valid"}, 128'(rk_valid), 128'(e.valid));
        check_output({tag, "_exprd_data"}, rk_data, e.data);
        check_output({tag, "_busy_ignored"}, 128'(busy), 128'(1'b1));
        check_output({tag, "_err_ignored"}, 128'(err), 128'(1'b0));
      end
      if (ready === 1'b1) break;
    end
    check_output({tag, "_latency"}, 128'(cnt), 128'(exp_lat));
    check_output({tag, "_busy_done"}, 128'(busy), 128'(1'b0));
    cur_ready = 1'b1;
  endtask

  initial begin
    build_sbox();
    rst     = 1'b1;
    key_in  = '0;
    key_len = 2'd0;
    start   = 1'b0;
    rk_rd   = 1'b0;
    rk_addr = 4'd0;
    repeat (3) tick();

    check_output("rst_busy", 128'(busy), 128'(1'b0));
    check_output("rst_ready", 128'(ready), 128'(1'b0));
    check_output("rst_err", 128'(err), 128'(1'b0));
    check_output("rst_rk_valid", 128'(rk_valid), 128'(1'b0));
    check_output("rst_rk_data", rk_data, 128'h0);
    check_output("rst_nr_out", 128'(nr_out), 128'(4'd0));
    rst = 1'b0;
    tick();

    // Illegal key length: one-cycle err, nothing else moves.
    key_len = 2'd3;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    key_len = 2'd0;
    check_output("bad_err_pulse", 128'(err), 128'(1'b1));
    check_output("bad_busy", 128'(busy), 128'(1'b0));
    check_output("bad_ready", 128'(ready), 128'(1'b0));
    tick();
    check_output("bad_err_clear", 128'(err), 128'(1'b0));
    check_output("bad_busy_after", 128'(busy), 128'(1'b0));
    do_read(0, "idle");

    // AES-128 with a start and a read injected mid-expansion.
    apply_stimulus(KEY128, 0, 42, 1'b1, 1'b0, "aes128");
    check_output("aes128_nr_out", 128'(nr_out), 128'(4'd10));
    do_read(10, "aes128_kat");
    check_output("aes128_round10", rk_data, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    sweep_reads("aes128");

    // AES-192.
    apply_stimulus(KEY192, 1, 48, 1'b0, 1'b0, "aes192");
    check_output("aes192_nr_out", 128'(nr_out), 128'(4'd12));
    do_read(12, "aes192_kat");
    check_output("aes192_w51", 128'(rk_data[31:0]), 128'(32'h01002202));
    sweep_reads("aes192");

    // Reset in the middle of an AES-128 expansion.
    key_in  = KEY128;
    key_len = 2'd0;
    start   = 1'b1;
    tick();
    start = 1'b0;
    repeat (20) tick();
    check_output("pre_rst_busy", 128'(busy), 128'(1'b1));
    rst = 1'b1;
    #1;
    check_output("rst_async_busy", 128'(busy), 128'(1'b0));
    tick();
    check_output("midrst_busy", 128'(busy), 128'(1'b0));
    check_output("midrst_ready", 128'(ready), 128'(1'b0));
    check_output("midrst_err", 128'(err), 128'(1'b0));
    check_output("midrst_nr_out", 128'(nr_out), 128'(4'd0));
    check_output("midrst_rk_valid", 128'(rk_valid), 128'(1'b0));
    cur_ready = 1'b0;
    cur_nr    = 0;
    rst = 1'b0;
    tick();
    do_read(0, "post_rst");

    // AES-256 after the aborted expansion.
    apply_stimulus(KEY256, 2, 54, 1'b0, 1'b0, "aes256");
    check_output("aes256_nr_out", 128'(nr_out), 128'(4'd14));
    do_read(14, "aes256_kat");
    check_output("aes256_w59", 128'(rk_data[31:0]), 128'(32'h706c631e));
    sweep_reads("aes256");

    // Back-to-back AES-128 from DONE, with a read of the old schedule on the start cycle.
    apply_stimulus(KEY128, 0, 42, 1'b0, 1'b1, "b2b128");
    check_output("b2b128_nr_out", 128'(nr_out), 128'(4'd10));
    do_read(10, "b2b128_kat");
    check_output("b2b128_round10", rk_data, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    sweep_reads("b2b128");

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
